// File: rtl/fp_align_pkg.sv
// Shared types and constants for the FP32 adder alignment front end.
package fp_align_pkg;

  localparam int unsigned EW_C      = 8;
  localparam int unsigned MW_C      = 24;
  localparam int unsigned SAT_LIMIT = MW_C + 2;

  typedef enum logic [1:0] {
    StIdle,
    StDiff,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/Sub_Result.sv
// 8-bit magnitude subtractor: Out = |A - B - Cin|, b = borrow of A - B - Cin.
module Sub_Result (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Out,
  output logic       b
);

  logic [8:0] raw_w;

  always_comb begin
    raw_w = {1'b0, A} - {1'b0, B} - {8'b0, Cin};
    b     = raw_w[8];
    Out   = raw_w[8] ? (8'd0 - raw_w[7:0]) : raw_w[7:0];
  end

endmodule

// File: rtl/fp_align_seq.sv
// Exponent compare / mantissa alignment sequencer for the FP32 adder front end.
// Optional sticky tracking is enabled with `define FP_ALIGN_STICKY_EN.
module fp_align_seq
  import fp_align_pkg::*;
#(
  parameter int unsigned MW         = MW_C,
  parameter int unsigned EW         = EW_C,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic [MW-1:0] man_a,
  input  logic [MW-1:0] man_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_big,
  output logic [MW-1:0] man_big,
  output logic [MW+1:0] man_small,
  output logic          sticky,
  output logic          swapped,
  output logic          busy
);

  localparam logic [EW-1:0] StepC = EW'(SHIFT_STEP);

  state_e        state_q;
  logic [EW-1:0] ea_q, eb_q, exp_big_q, rem_q;
  logic [MW-1:0] ma_q, mb_q, man_big_q;
  logic [MW+1:0] small_q;
  logic          swapped_q, out_valid_q, in_ready_q, busy_q;

  logic [EW-1:0] diff_w;
  logic          borrow_w;
  logic [MW-1:0] man_small_in_w;
  logic          sat_w;
  logic [EW-1:0] k_w;
  logic [MW+1:0] small_d;

  Sub_Result u_sub (
    .A   (ea_q),
    .B   (eb_q),
    .Cin (1'b0),
    .Out (diff_w),
    .b   (borrow_w)
  );

  always_comb begin
    man_small_in_w = borrow_w ? ma_q : mb_q;
    sat_w          = 32'(diff_w) >= 32'(MW + 2);
    k_w            = (rem_q < StepC) ? rem_q : StepC;
    small_d        = small_q >> k_w;
  end

`ifdef FP_ALIGN_STICKY_EN
  logic          sticky_q;
  logic [MW+1:0] mask_w;
  logic          shifted_out_w;

  always_comb begin
    mask_w        = ~({(MW + 2){1'b1}} << k_w);
    shifted_out_w = |(small_q & mask_w);
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      exp_big_q   <= '0;
      man_big_q   <= '0;
      small_q     <= '0;
      rem_q       <= '0;
      swapped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ea_q       <= exp_a;
            eb_q       <= exp_b;
            ma_q       <= man_a;
            mb_q       <= man_b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StDiff;
          end
        end
        StDiff: begin
          swapped_q <= borrow_w;
          exp_big_q <= borrow_w ? eb_q : ea_q;
          man_big_q <= borrow_w ? mb_q : ma_q;
          rem_q     <= diff_w;
          if (diff_w == '0) begin
            small_q     <= {man_small_in_w, 2'b00};
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= 1'b0;
`endif
          end else if (sat_w) begin
            small_q     <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= |man_small_in_w;
`endif
          end else begin
            small_q     <= {man_small_in_w, 2'b00};
            state_q     <= StShift;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= 1'b0;
`endif
          end
        end
        StShift: begin
          small_q <= small_d;
          rem_q   <= rem_q - k_w;
`ifdef FP_ALIGN_STICKY_EN
          sticky_q <= sticky_q | shifted_out_w;
`endif
          if (rem_q == k_w) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign exp_big   = exp_big_q;
  assign man_big   = man_big_q;
  assign man_small = small_q;
  assign swapped   = swapped_q;

endmodule

// File: doc/fp_align_seq.md
# fp_align_seq

Multi-cycle exponent-compare and mantissa-alignment sequencer for the FP32 adder front end. It accepts one operand pair over a valid/ready handshake. It drives the shared 8-bit magnitude subtractor to obtain |Ea−Eb| and the borrow, and swaps the operands so the larger exponent is on the "big" side. It then right-shifts the smaller mantissa a bounded number of bits per cycle and presents the aligned pair to the add/normalise stage over a second valid/ready handshake.

## Interface
Parameters:
- `MW`, 24 — mantissa width including hidden bit.
- `EW`, 8 — exponent width; fixed by the subtractor.
- `SHIFT_STEP`, 4 — maximum right-shift bits per SHIFT cycle; legal range 1..8.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — operand pair valid.
- `in_ready` out 1 — block can accept; high only in IDLE.
- `exp_a`, `exp_b` in EW — biased exponents.
- `man_a`, `man_b` in MW — mantissas with hidden bit.
- `out_valid` out 1 — aligned result valid.
- `out_ready` in 1 — downstream accepts.
- `exp_big` out EW — larger exponent.
- `man_big` out MW — mantissa paired with `exp_big`.
- `man_small` out MW+2 — aligned smaller mantissa; bit 1 is guard, bit 0 is round.
- `sticky` out 1 — OR of all bits shifted out below the round bit.
- `swapped` out 1 — operand B was the larger.
- `busy` out 1 — state is not IDLE.

## Operation
- FSM states: IDLE, DIFF, SHIFT, DONE.
- IDLE: when `in_valid & in_ready`, register both operands and go to DIFF.
- DIFF:
  - Subtractor inputs are the registered `exp_a`/`exp_b`. Capture `d = |Ea−Eb|` and `b = borrow`.
  - If `b=1`, swap: big = B, small = A, `swapped=1`. If `b=0` (including Ea==Eb), big = A.
  - Load the small register with {man_small_in, 2'b00} and clear sticky.
  - If `d=0`, go to DONE.
  - If `d >= MW+2` (saturation), set small = 0, sticky = |man_small_in, and go to DONE.
  - Otherwise load `rem=d` and go to SHIFT.
- SHIFT, each cycle:
  - `k = min(rem, SHIFT_STEP)`.
  - small ← small >> k; sticky |= OR of the k bits shifted out; rem ← rem − k.
  - When rem reaches 0, go to DONE.
- DONE: `out_valid=1`. Outputs are held stable until `out_ready`. On the handshake, go to IDLE.
- `rem` is EW bits wide and never underflows, because k ≤ rem.
- Reset, applied at any time including mid-SHIFT or mid-DONE:
  - Next state is IDLE and all registers clear.
  - The partial result is discarded and no `out_valid` is issued.

## Timing
- Reset values: `in_ready=1` (IDLE), `out_valid=0`, `busy=0`, and `exp_big`/`man_big`/`man_small`/`sticky`/`swapped` all 0.
- Latency, with the input handshake in cycle 0:
  - `out_valid` first rises in cycle 2 + ceil(d/SHIFT_STEP) when 0 < d < MW+2.
  - It rises in cycle 2 when d=0 or the shift saturates.
- Throughput: one operation in flight. `in_ready` is low from DIFF through the DONE handshake cycle. The earliest next accept is the cycle after the output handshake.
- Outputs are registered. There is no combinational path from `in_*` to `out_*`. `out_ready` affects only the DONE→IDLE transition.

## Configuration
- `FP_ALIGN_STICKY_EN` defined: sticky is computed as above, both in SHIFT and on saturation.
- `FP_ALIGN_STICKY_EN` undefined:
  - `sticky` is tied to 0 and shifted-out bits are discarded.
  - The sticky register and its OR-reduction logic are removed.
  - All other behaviour and timing are unchanged.

## Structure
- Shared package `fp_align_pkg` holds:
  - the state enum (IDLE/DIFF/SHIFT/DONE);
  - localparams `EW_C=8`, `MW_C=24`, and `SAT_LIMIT=MW_C+2`.
- One sub-module: the existing `Sub_Result` 8-bit magnitude subtractor, instantiated once with `Cin=0`. Its `Out` is d and its `b` is the swap flag.
- The shifter and FSM live in the top file.

## Test plan
- Diff 3, no swap:
  - Stimulus: Ea=0x85, Eb=0x82, Ma=0x800000, Mb=0xC00000, SHIFT_STEP=4.
  - Response: exp_big=0x85, man_big=0x800000, man_small=0x0600000, sticky=0, swapped=0, out_valid in cycle 3.
- Equal exponents:
  - Stimulus: Ea=Eb=0x7F, Mb=0xABCDEF.
  - Response: swapped=0, man_small=0x2AF37BC, sticky=0, out_valid in cycle 2.
- Swap and sticky:
  - Stimulus: Ea=0x80, Eb=0x90, Ma=0x800001.
  - Response: swapped=1, exp_big=0x90, man_small=0x0000200, sticky=1, out_valid in cycle 6.
- Saturation:
  - Stimulus: Ea=0xFE, Eb=0x01, Mb=0x800000.
  - Response: man_small=0, sticky=1, out_valid in cycle 2.
  - With the macro undefined: sticky=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Response: outputs stable, in_ready=0, new operands not accepted. The accept occurs the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst in the second SHIFT cycle of the diff-16 case.
  - Response: the next cycle shows busy=0, in_ready=1, out_valid=0, and every later cycle shows no stale out_valid.
